// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write counters driving decode stall; define SCOREBOARD_BYPASS_EN to let same-cycle completions release the stall
module register_scoreboard #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int NUM_REGS = 2**REGISTER_INDEX_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
)(
  input  logic clk,
  input  logic rst_n,
  input  logic decode_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_1,
  input  logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_2,
  input  logic issue_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_dst,
  output logic issue_ready,
  input  logic alu_done_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] alu_done_idx,
  input  logic mem_done_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] mem_done_idx,
  input  logic flush,
  output logic stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
  output logic protocol_error
);
  logic [1:0] pend [NUM_REGS];
  logic [1:0] nxt [NUM_REGS];
  logic [1:0] dec [NUM_REGS];
  logic [NUM_REGS-1:0] busy_eff;
  logic [2:0] up, diff;
  logic accept, alu_err, mem_err;
  assign issue_ready = pend[issue_idx_dst] != 2'd3;
  assign stall = decode_valid && ((decode_idx_src_1 != '0 && busy_eff[decode_idx_src_1]) ||
                                  (decode_idx_src_2 != '0 && busy_eff[decode_idx_src_2]));
  assign accept = issue_valid && issue_ready && !stall;
  assign alu_err = alu_done_valid && alu_done_idx != '0 && pend[alu_done_idx] == 2'd0;
  assign mem_err = mem_done_valid && mem_done_idx != '0 && pend[mem_done_idx] == 2'd0;
  always_comb begin
    up = '0;
    diff = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = 2'(alu_done_valid && alu_done_idx == REGISTER_INDEX_WIDTH'(i)) +
               2'(mem_done_valid && mem_done_idx == REGISTER_INDEX_WIDTH'(i));
      up = 3'(pend[i]) + 3'(accept && issue_idx_dst == REGISTER_INDEX_WIDTH'(i));
      diff = up - 3'(dec[i]);
      nxt[i] = (i == 0 || up <= 3'(dec[i])) ? 2'd0 : diff > 3'd3 ? 2'd3 : diff[1:0];
      busy_mask[i] = pend[i] != 2'd0;
`ifdef SCOREBOARD_BYPASS_EN
      busy_eff[i] = busy_mask[i] && pend[i] != dec[i];
`else
      busy_eff[i] = busy_mask[i];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= 2'd0;
      stall_cycles <= '0;
      protocol_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= flush ? 2'd0 : nxt[i];
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
      if (!flush && (alu_err || mem_err)) protocol_error <= 1'b1;
    end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed checks of issue, completion, stall, flush and reset behaviour
module tb_register_scoreboard;
  logic clk = 0, rst_n = 1;
  logic decode_valid, issue_valid, alu_done_valid, mem_done_valid, flush;
  logic [4:0] decode_idx_src_1, decode_idx_src_2, issue_idx_dst, alu_done_idx, mem_done_idx;
  logic issue_ready, stall, protocol_error;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;
  int pass_n = 0, tot_n = 0;
  register_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .decode_valid(decode_valid),
    .decode_idx_src_1(decode_idx_src_1), .decode_idx_src_2(decode_idx_src_2),
    .issue_valid(issue_valid), .issue_idx_dst(issue_idx_dst), .issue_ready(issue_ready),
    .alu_done_valid(alu_done_valid), .alu_done_idx(alu_done_idx),
    .mem_done_valid(mem_done_valid), .mem_done_idx(mem_done_idx),
    .flush(flush), .stall(stall), .busy_mask(busy_mask),
    .stall_cycles(stall_cycles), .protocol_error(protocol_error));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    decode_valid = 0; decode_idx_src_1 = 0; decode_idx_src_2 = 0;
    issue_valid = 0; issue_idx_dst = 0;
    alu_done_valid = 0; alu_done_idx = 0;
    mem_done_valid = 0; mem_done_idx = 0;
    flush = 0;
  endtask
  task automatic do_reset;
    rst_n = 0;
    #1;
    tick;
    rst_n = 1;
    #1;
  endtask
  initial begin
    idle;
    decode_valid = 1; decode_idx_src_1 = 5; issue_idx_dst = 5;
    #1 rst_n = 0;
    #1;
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_perr", protocol_error, 0);
    tick;
    rst_n = 1;
    idle;
    // issue r5, then dependent decode stalls until the ALU writes back
    issue_valid = 1; issue_idx_dst = 5;
    tick;
    idle;
    decode_valid = 1; decode_idx_src_1 = 5;
    #1;
    chk("r5_stall", stall, 1);
    chk("r5_busy", busy_mask, 32'h20);
    alu_done_valid = 1; alu_done_idx = 5;
    #1;
`ifdef SCOREBOARD_BYPASS_EN
    chk("r5_bypass_stall", stall, 0);
`else
    chk("r5_done_cycle_stall", stall, 1);
`endif
    tick;
    alu_done_valid = 0;
    #1;
    chk("r5_clear_stall", stall, 0);
    chk("r5_clear_busy", busy_mask, 0);
    chk("r5_perr", protocol_error, 0);
    // r0 is never tracked
    idle;
    issue_valid = 1; issue_idx_dst = 0;
    tick;
    idle;
    decode_valid = 1;
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_busy", busy_mask, 0);
    chk("r0_perr", protocol_error, 0);
    // r7 saturates at three outstanding writes
    idle;
    issue_valid = 1; issue_idx_dst = 7;
    repeat (3) tick;
    chk("r7_busy", busy_mask, 32'h80);
    chk("r7_ready", issue_ready, 0);
    tick;
    idle;
    mem_done_valid = 1; mem_done_idx = 7;
    repeat (2) tick;
    chk("r7_busy_after2", busy_mask, 32'h80);
    tick;
    idle;
    #1;
    chk("r7_busy_after3", busy_mask, 0);
    chk("r7_perr", protocol_error, 0);
    // r9: pend 2, issue plus two completions nets to 1
    issue_valid = 1; issue_idx_dst = 9;
    repeat (2) tick;
    alu_done_valid = 1; alu_done_idx = 9; mem_done_valid = 1; mem_done_idx = 9;
    tick;
    idle;
    #1;
    chk("r9_busy", busy_mask, 32'h200);
    alu_done_valid = 1; alu_done_idx = 9;
    tick;
    idle;
    #1;
    chk("r9_drained", busy_mask, 0);
    chk("r9_perr", protocol_error, 0);
    // r10: double completion with pend 1 saturates at 0 without error
    issue_valid = 1; issue_idx_dst = 10;
    tick;
    idle;
    alu_done_valid = 1; alu_done_idx = 10; mem_done_valid = 1; mem_done_idx = 10;
    tick;
    idle;
    #1;
    chk("r10_busy", busy_mask, 0);
    chk("r10_perr", protocol_error, 0);
    // four stalled cycles then flush
    do_reset;
    chk("rst2_cnt", stall_cycles, 0);
    issue_valid = 1; issue_idx_dst = 12;
    tick;
    idle;
    decode_valid = 1; decode_idx_src_2 = 12;
    issue_valid = 1; issue_idx_dst = 13;
    #1;
    chk("stall_ready_high", issue_ready, 1);
    repeat (4) tick;
    chk("stalled_issue_dropped", busy_mask, 32'h1000);
    idle;
    flush = 1;
    issue_valid = 1; issue_idx_dst = 14;
    alu_done_valid = 1; alu_done_idx = 3;
    tick;
    idle;
    decode_valid = 1; decode_idx_src_2 = 12;
    #1;
    chk("flush_cnt", stall_cycles, 4);
    chk("flush_busy", busy_mask, 0);
    chk("flush_stall", stall, 0);
    chk("flush_perr", protocol_error, 0);
    // completion to idle register sets sticky error
    idle;
    alu_done_valid = 1; alu_done_idx = 3;
    tick;
    idle;
    #1;
    chk("perr_set", protocol_error, 1);
    flush = 1;
    repeat (3) tick;
    idle;
    #1;
    chk("perr_sticky", protocol_error, 1);
    chk("cnt_kept", stall_cycles, 4);
    // reset mid-stall clears at once; stale completion then errors
    issue_valid = 1; issue_idx_dst = 20;
    tick;
    idle;
    decode_valid = 1; decode_idx_src_1 = 20;
    repeat (2) tick;
    chk("pre_rst_cnt", stall_cycles, 6);
    rst_n = 0;
    #1;
    chk("async_busy", busy_mask, 0);
    chk("async_stall", stall, 0);
    chk("async_cnt", stall_cycles, 0);
    chk("async_perr", protocol_error, 0);
    chk("async_ready", issue_ready, 1);
    tick;
    rst_n = 1;
    idle;
    alu_done_valid = 1; alu_done_idx = 20;
    tick;
    idle;
    #1;
    chk("stale_perr", protocol_error, 1);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
